gate_sequencer: RTL and testbench

Control unit that sits between the SPI field decoder and the garbling datapath. It consumes the decoder's per-field strobes and fetches the input wire labels from label memory. It evaluates each gate:
- XOR: free-XOR
- BUF: copy
- AND: hash engine plus one of three buffered ciphertext rows

It then writes the output label back to label memory at the gate's output id. One gate is in flight at a time, and `busy` provides host backpressure.

---
 rtl/gc_pkg.sv | 25 ++
 rtl/gate_sequencer_if.sv | 32 +++
 rtl/gc_row_select.sv | 24 ++
 rtl/gate_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_gate_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gc_pkg.sv
// Shared definitions for the garbled-circuit gate sequencer: default widths,
// gate type encodings and the sequencer state enumeration.
package gc_pkg;

    localparam int unsigned DEFAULT_LABEL_W = 128;
    localparam int unsigned DEFAULT_ID_W    = 13;

    localparam logic [1:0] AND_GATE  = 2'd0;
    localparam logic [1:0] XOR_GATE  = 2'd1;
    localparam logic [1:0] BUF_GATE  = 2'd2;
    localparam logic [1:0] RSVD_GATE = 2'd3;

    typedef enum logic [3:0] {
        StIdle,
        StWaitA,
        StLatchA,
        StWaitB,
        StLatchB,
        StWaitOut,
        StHashReq,
        StHashWait,
        StWrite
    } state_e;

endpackage

// File: rtl/gate_sequencer_if.sv
// Label memory and hash engine bus between the gate sequencer (master) and
// the memory / hash engine (slave).
interface gate_sequencer_if #(
    parameter int unsigned LABEL_W = gc_pkg::DEFAULT_LABEL_W,
    parameter int unsigned ID_W    = gc_pkg::DEFAULT_ID_W
) ();

    logic [ID_W-1:0]    mem_addr;
    logic               mem_rd_en;
    logic [LABEL_W-1:0] mem_rdata;
    logic               mem_wr_en;
    logic [LABEL_W-1:0] mem_wdata;
    logic               hash_start;
    logic [LABEL_W-1:0] hash_a;
    logic [LABEL_W-1:0] hash_b;
    logic [ID_W-1:0]    hash_tweak;
    logic               hash_done;
    logic [LABEL_W-1:0] hash_out;

    modport master (
        output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        output hash_start, hash_a, hash_b, hash_tweak,
        input  mem_rdata, hash_done, hash_out
    );

    modport slave (
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        input  hash_start, hash_a, hash_b, hash_tweak,
        output mem_rdata, hash_done, hash_out
    );

endinterface

// File: rtl/gc_row_select.sv
// AND-gate result selection: the hash output is used directly for s = 0,
// otherwise it is masked with ciphertext row s-1.
module gc_row_select import gc_pkg::*; #(
    parameter int unsigned LABEL_W = DEFAULT_LABEL_W
) (
    input  logic [LABEL_W-1:0] hash_out_i,
    input  logic [LABEL_W-1:0] row0_i,
    input  logic [LABEL_W-1:0] row1_i,
    input  logic [LABEL_W-1:0] row2_i,
    input  logic [1:0]         sel_i,
    output logic [LABEL_W-1:0] result_o
);

    // Pick the ciphertext row addressed by the colour bits
    always_comb begin
        unique case (sel_i)
            2'd0:    result_o = hash_out_i;
            2'd1:    result_o = hash_out_i ^ row0_i;
            2'd2:    result_o = hash_out_i ^ row1_i;
            default: result_o = hash_out_i ^ row2_i;
        endcase
    end

endmodule

// File: rtl/gate_sequencer.sv
// Gate sequencer: turns decoder field strobes into label reads, hash engine
// requests and one output label write per gate. One gate in flight.
// Optional GATE_SEQUENCER_STATS_EN adds saturating per-type gate counters.
module gate_sequencer import gc_pkg::*; #(
    parameter int unsigned LABEL_W = DEFAULT_LABEL_W,
    parameter int unsigned ID_W    = DEFAULT_ID_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         gate_type_i,
    input  logic [ID_W-1:0]    input_id_i,
    input  logic [LABEL_W-1:0] ctxt_i,
    input  logic [1:0]         ctxt_idx_i,
    input  logic [ID_W-1:0]    gate_id_i,
    input  logic               gate_strobe_i,
    input  logic               id_1_strobe_i,
    input  logic               id_2_strobe_i,
    input  logic               ctxt_strobe_i,
    input  logic               gate_id_strobe_i,
    gate_sequencer_if.master   bus_io,
    output logic               busy_o,
    output logic               gate_done_o,
    output logic               error_o
`ifdef GATE_SEQUENCER_STATS_EN
    ,
    output logic [15:0]        and_count_o,
    output logic [15:0]        xor_count_o,
    output logic [15:0]        buf_count_o
`endif
);

    state_e             state_q;
    logic [1:0]         type_q;
    logic [LABEL_W-1:0] a_q, b_q, result_q;
    logic [LABEL_W-1:0] row0_q, row1_q, row2_q;
    logic [2:0]         row_vld_q;
    logic [ID_W-1:0]    gate_id_q;
    logic               error_q;

    logic [1:0]         slot;
    logic               is_and;
    logic               unexpected;
    logic               bad_field;
    logic [LABEL_W-1:0] and_result;

    assign slot   = ctxt_idx_i - 2'd1;
    assign is_and = (type_q == AND_GATE);

    gc_row_select #(
        .LABEL_W(LABEL_W)
    ) u_row_select (
        .hash_out_i(bus_io.hash_out),
        .row0_i    (row0_q),
        .row1_i    (row1_q),
        .row2_i    (row2_q),
        .sel_i     ({a_q[0], b_q[0]}),
        .result_o  (and_result)
    );

    // Protocol checks: strobes outside their state, and malformed fields
    always_comb begin
        unexpected = (gate_strobe_i && state_q != StIdle)
                  || (id_1_strobe_i && state_q != StWaitA)
                  || (id_2_strobe_i && state_q != StWaitB)
                  || (ctxt_strobe_i && !(state_q == StWaitOut && is_and))
                  || (gate_id_strobe_i && state_q != StWaitOut)
                  || (bus_io.hash_done && state_q != StHashWait);
        bad_field  = (gate_strobe_i && state_q == StIdle && gate_type_i == RSVD_GATE)
                  || (ctxt_strobe_i && state_q == StWaitOut && is_and && slot == 2'd3)
                  || (gate_id_strobe_i && state_q == StWaitOut && is_and && !(&row_vld_q));
    end

    // Gate FSM with its datapath registers and the sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            type_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            row0_q    <= '0;
            row1_q    <= '0;
            row2_q    <= '0;
            row_vld_q <= '0;
            gate_id_q <= '0;
            error_q   <= 1'b0;
        end else begin
            error_q <= error_q | unexpected | bad_field;
            unique case (state_q)
                StIdle: begin
                    if (gate_strobe_i && gate_type_i != RSVD_GATE) begin
                        type_q    <= gate_type_i;
                        row_vld_q <= '0;
                        state_q   <= StWaitA;
                    end
                end
                StWaitA: if (id_1_strobe_i) state_q <= StLatchA;
                StLatchA: begin
                    a_q     <= bus_io.mem_rdata;
                    state_q <= (type_q == BUF_GATE) ? StWaitOut : StWaitB;
                end
                StWaitB: if (id_2_strobe_i) state_q <= StLatchB;
                StLatchB: begin
                    b_q     <= bus_io.mem_rdata;
                    state_q <= StWaitOut;
                end
                StWaitOut: begin
                    if (ctxt_strobe_i && is_and) begin
                        unique case (slot)
                            2'd0: begin row0_q <= ctxt_i; row_vld_q[0] <= 1'b1; end
                            2'd1: begin row1_q <= ctxt_i; row_vld_q[1] <= 1'b1; end
                            2'd2: begin row2_q <= ctxt_i; row_vld_q[2] <= 1'b1; end
                            default: ;
                        endcase
                    end
                    if (gate_id_strobe_i) begin
                        gate_id_q <= gate_id_i;
                        if (is_and) begin
                            // An AND gate without all three rows cannot be evaluated
                            state_q <= (&row_vld_q) ? StHashReq : StIdle;
                        end else begin
                            result_q <= (type_q == BUF_GATE) ? a_q : (a_q ^ b_q);
                            state_q  <= StWrite;
                        end
                    end
                end
                StHashReq: state_q <= StHashWait;
                StHashWait: begin
                    if (bus_io.hash_done) begin
                        result_q <= and_result;
                        state_q  <= StWrite;
                    end
                end
                StWrite: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output decode; the read request follows the id strobe in the same cycle
    // so the label arrives while the FSM sits in the latch state.
    always_comb begin
        bus_io.mem_addr   = '0;
        bus_io.mem_rd_en  = 1'b0;
        bus_io.mem_wr_en  = 1'b0;
        bus_io.mem_wdata  = '0;
        bus_io.hash_start = 1'b0;
        bus_io.hash_a     = '0;
        bus_io.hash_b     = '0;
        bus_io.hash_tweak = '0;
        gate_done_o       = 1'b0;
        if ((state_q == StWaitA && id_1_strobe_i) || (state_q == StWaitB && id_2_strobe_i)) begin
            bus_io.mem_addr  = input_id_i;
            bus_io.mem_rd_en = 1'b1;
        end
        if (state_q == StHashReq) begin
            bus_io.hash_start = 1'b1;
            bus_io.hash_a     = a_q;
            bus_io.hash_b     = b_q;
            bus_io.hash_tweak = gate_id_q;
        end
        if (state_q == StWrite) begin
            bus_io.mem_addr  = gate_id_q;
            bus_io.mem_wr_en = 1'b1;
            bus_io.mem_wdata = result_q;
            gate_done_o      = 1'b1;
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign error_o = error_q;

`ifdef GATE_SEQUENCER_STATS_EN
    logic [15:0] and_cnt_q, xor_cnt_q, buf_cnt_q;

    // Saturating per-type counts of completed gates
    always_ff @(posedge clk) begin
        if (rst) begin
            and_cnt_q <= '0;
            xor_cnt_q <= '0;
            buf_cnt_q <= '0;
        end else if (state_q == StWrite) begin
            unique case (type_q)
                AND_GATE: if (and_cnt_q != 16'hFFFF) and_cnt_q <= and_cnt_q + 16'd1;
                XOR_GATE: if (xor_cnt_q != 16'hFFFF) xor_cnt_q <= xor_cnt_q + 16'd1;
                BUF_GATE: if (buf_cnt_q != 16'hFFFF) buf_cnt_q <= buf_cnt_q + 16'd1;
                default: ;
            endcase
        end
    end

    assign and_count_o = and_cnt_q;
    assign xor_count_o = xor_cnt_q;
    assign buf_count_o = buf_cnt_q;
`endif

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer: label memory model, stub hash engine,
// table of gates plus hand sequences for protocol errors and mid-gate reset.
module tb_gate_sequencer;
    import gc_pkg::*;

    typedef struct {
        logic [1:0]   gtype;
        logic [12:0]  ida;
        logic [12:0]  idb;
        logic [12:0]  idout;
        int           hdelay;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] HASH_VAL = {16{8'hF0}};

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   gate_type;
    logic [12:0]  input_id;
    logic [127:0] ctxt;
    logic [1:0]   ctxt_idx;
    logic [12:0]  gate_id;
    logic         gate_strobe, id_1_strobe, id_2_strobe, ctxt_strobe, gate_id_strobe;
    logic         busy, gate_done, error;

    logic [127:0] mem [0:8191];
    logic [127:0] rows [3];
    vec_t         vecs [7];
    int           wr_cnt = 0;
    int           hcnt = 0;
    int           hash_delay = 4;
    int           n_checks = 0;
    int           n_fail = 0;

    gate_sequencer_if #(.LABEL_W(128), .ID_W(13)) bus ();

`ifdef GATE_SEQUENCER_STATS_EN
    logic [15:0] and_count, xor_count, buf_count;
`endif

    gate_sequencer #(.LABEL_W(128), .ID_W(13)) dut (
        .clk             (clk),
        .rst             (rst),
        .gate_type_i     (gate_type),
        .input_id_i      (input_id),
        .ctxt_i          (ctxt),
        .ctxt_idx_i      (ctxt_idx),
        .gate_id_i       (gate_id),
        .gate_strobe_i   (gate_strobe),
        .id_1_strobe_i   (id_1_strobe),
        .id_2_strobe_i   (id_2_strobe),
        .ctxt_strobe_i   (ctxt_strobe),
        .gate_id_strobe_i(gate_id_strobe),
        .bus_io          (bus),
        .busy_o          (busy),
        .gate_done_o     (gate_done),
        .error_o         (error)
`ifdef GATE_SEQUENCER_STATS_EN
        ,
        .and_count_o     (and_count),
        .xor_count_o     (xor_count),
        .buf_count_o     (buf_count)
`endif
    );

    always #5 clk = ~clk;

    // Label memory: one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            wr_cnt = wr_cnt + 1;
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Hash stub: done pulse hash_delay cycles after hash_start
    always @(posedge clk) begin
        if (rst) hcnt = 0;
        else if (bus.hash_start) hcnt = hash_delay;
        else if (hcnt > 0) hcnt = hcnt - 1;
        bus.hash_done <= (hcnt == 1);
        bus.hash_out  <= (hcnt == 1) ? HASH_VAL : '0;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        check({name, " ctrl"}, 128'({busy, error, gate_done, bus.mem_wr_en, bus.mem_rd_en,
                                     bus.hash_start}), '0);
        check({name, " addr"}, 128'(bus.mem_addr), '0);
        check({name, " wdata"}, bus.mem_wdata, '0);
        check({name, " hash_ab"}, bus.hash_a | bus.hash_b | 128'(bus.hash_tweak), '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic run_gate(input vec_t v, input int nrows, input bit inj, input bit rst_mid,
                            input bit exp_err, input bit exp_wr);
        int wr_base;
        bit seen;
        wr_base    = wr_cnt;
        hash_delay = v.hdelay;
        gate_type  = v.gtype;
        gate_strobe = 1'b1;
        tick();
        gate_strobe = 1'b0;
        input_id    = v.ida;
        id_1_strobe = 1'b1;
        @(negedge clk);
        check("rd_en A", 128'({bus.mem_rd_en, bus.mem_addr}), 128'({1'b1, v.ida}));
        tick();
        id_1_strobe = 1'b0;
        tick();
        if (v.gtype != BUF_GATE) begin
            input_id    = v.idb;
            id_2_strobe = 1'b1;
            tick();
            id_2_strobe = 1'b0;
            tick();
        end
        for (int r = 0; r < nrows; r++) begin
            ctxt        = rows[r];
            ctxt_idx    = 2'(r + 1);
            ctxt_strobe = 1'b1;
            tick();
            ctxt_strobe = 1'b0;
        end
        gate_id        = v.idout;
        gate_id_strobe = 1'b1;
        tick();
        gate_id_strobe = 1'b0;
        @(negedge clk);
        if (!exp_wr) begin
            check("drop wr/busy/hs", 128'({bus.mem_wr_en, busy, bus.hash_start}), '0);
            repeat (3) tick();
            check("drop no write", 128'(wr_cnt - wr_base), '0);
        end else if (v.gtype != AND_GATE) begin
            check("T+1 write", 128'({bus.mem_wr_en, gate_done, bus.mem_addr}),
                  128'({2'b11, v.idout}));
            check("T+1 wdata", bus.mem_wdata, v.exp);
            tick();
            @(negedge clk);
            check("T+2 busy", 128'(busy), '0);
        end else begin
            check("hash_start T+1", 128'({bus.hash_start, bus.hash_tweak}), 128'({1'b1, v.idout}));
            check("hash_a", bus.hash_a, mem[v.ida]);
            check("hash_b", bus.hash_b, mem[v.idb]);
            if (rst_mid) begin
                tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                @(negedge clk);
                check_quiet("after mid reset");
                repeat (8) tick();
                check("mid reset no write", 128'(wr_cnt - wr_base), '0);
                return;
            end
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick();
                gate_strobe = inj && (c == 0);
                gate_type   = XOR_GATE;
                @(negedge clk);
                seen = bus.hash_done;
            end
            gate_strobe = 1'b0;
            check("hash_done seen", 128'(seen), 128'(1));
            tick();
            @(negedge clk);
            check("H+1 write", 128'({bus.mem_wr_en, gate_done, bus.mem_addr}),
                  128'({2'b11, v.idout}));
            check("H+1 wdata", bus.mem_wdata, v.exp);
            tick();
            @(negedge clk);
            check("H+2 busy", 128'(busy), '0);
        end
        tick();
        check("error flag", 128'(error), 128'(exp_err));
        if (exp_wr) check("mem result", mem[v.idout], v.exp);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        gate_type = '0; input_id = '0; ctxt = '0; ctxt_idx = '0; gate_id = '0;
        gate_strobe = 1'b0; id_1_strobe = 1'b0; id_2_strobe = 1'b0;
        ctxt_strobe = 1'b0; gate_id_strobe = 1'b0;

        mem[5]  = {16{8'h11}};
        mem[9]  = {16{8'h22}};
        mem[7]  = {16{8'hA5}};
        mem[40] = {16{8'h3C}};  // lsb 0
        mem[41] = {16{8'h5B}};  // lsb 1
        mem[42] = {16{8'h66}};  // lsb 0
        mem[43] = {16{8'h99}};  // lsb 1
        rows[0] = {16{8'h12}};
        rows[1] = {16{8'h34}};
        rows[2] = {16{8'h56}};

        vecs[0] = '{XOR_GATE, 13'd5,  13'd9,  13'd20,  4, {16{8'h33}}};
        vecs[1] = '{BUF_GATE, 13'd7,  13'd0,  13'd300, 4, {16{8'hA5}}};
        vecs[2] = '{AND_GATE, 13'd40, 13'd42, 13'd100, 4, {16{8'hF0}}};
        vecs[3] = '{AND_GATE, 13'd40, 13'd43, 13'd101, 4, {16{8'hE2}}};
        vecs[4] = '{AND_GATE, 13'd41, 13'd42, 13'd102, 4, {16{8'hC4}}};
        vecs[5] = '{AND_GATE, 13'd41, 13'd43, 13'd103, 1, {16{8'hA6}}};
        vecs[6] = '{XOR_GATE, 13'd5,  13'd5,  13'd21,  4, 128'd0};

        repeat (3) tick();
        @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_gate(vecs[i], (vecs[i].gtype == AND_GATE) ? 3 : 0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
`ifdef GATE_SEQUENCER_STATS_EN
        check("stats", 128'({and_count, xor_count, buf_count}), 128'({16'd4, 16'd2, 16'd1}));
`endif

        // gate_strobe during HASH_WAIT: flagged, gate still completes
        do_reset();
        run_gate(vecs[2], 3, 1'b1, 1'b0, 1'b1, 1'b1);

        // stray ctxt_strobe on an XOR gate
        do_reset();
        run_gate(vecs[0], 1, 1'b0, 1'b0, 1'b1, 1'b1);

        // AND with only two rows is dropped
        do_reset();
        run_gate(vecs[3], 2, 1'b0, 1'b0, 1'b1, 1'b0);

        // reset in HASH_WAIT aborts, next XOR gate is clean
        do_reset();
        run_gate(vecs[4], 3, 1'b0, 1'b1, 1'b0, 1'b1);
        v = vecs[0];
        v.idout = 13'd22;
        run_gate(v, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
